execute_stage: RTL and testbench
================================

# execute_stage

Execute stage of the SIMD processor. It consumes the registered opcode, operand vectors and store address produced by the decode stage, holds the A/B operand registers and the result register, and performs lane-wise ADD/SUB/MUL and a DOT reduction across `PE_ELEMENTS` lanes. It issues result writes to the data memory on STORE and halts on STOP. It is the last pipeline stage; nothing sits downstream except data memory.

## Interface
- `PE_ELEMENTS`, 4: number of lanes.
- `DMEM_DEPTH`, 1024: data memory depth in words.
- `DATA_LEN`, 32: lane width, two's complement.
- `DMEM_ADDR_WIDTH`, localparam `$clog2(DMEM_DEPTH/PE_ELEMENTS)`: vector address width, 8 by default.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `opcode` in 4: decoded opcode, registered by decode.
- `data_a` in `PE_ELEMENTS*DATA_LEN`: matrix A read data, valid in the cycle `opcode`=LOAD_A.
- `data_b` in `PE_ELEMENTS*DATA_LEN`: matrix B read data, valid in the cycle `opcode`=LOAD_B.
- `write_addr` in `DMEM_ADDR_WIDTH`: store address, valid in the cycle `opcode`=STORE.
- `dmem_we` out 1: result memory write enable.
- `dmem_addr` out `DMEM_ADDR_WIDTH`: result memory vector address.
- `dmem_wdata` out `PE_ELEMENTS*DATA_LEN`: result vector.
- `halted` out 1: STOP has executed; sticky.
- `illegal` out 1: an opcode in 11–15 was seen; sticky.
- `ovf` out 1: arithmetic overflow occurred; sticky.
- `instr_count` out 16: count of executed non-NOP opcodes, saturating at 0xFFFF.

## Operation
- Opcode encoding: NOP=0, LOAD_A=1, LOAD_B=2, ADD=3, SUB=4, MUL=5, DOT=6, BUFFER_RES_1=7, BUFFER_RES_2=8, STORE=9, STOP=10.
- Internal registers: `reg_a`, `reg_b`, `result`, each `PE_ELEMENTS*DATA_LEN` wide.
- Each opcode, sampled on the rising clock edge:
  - LOAD_A: `reg_a <= data_a`.
  - LOAD_B: `reg_b <= data_b`.
  - ADD / SUB / MUL: per lane, `result[i] <= reg_a[i] op reg_b[i]`. MUL keeps the low `DATA_LEN` bits of the signed product.
  - DOT: `result[0] <= Σ reg_a[i]*reg_b[i]`, truncated to `DATA_LEN`; all other lanes <= 0.
  - BUFFER_RES_1: `reg_a <= result`. BUFFER_RES_2: `reg_b <= result`.
  - STORE: next cycle `dmem_we=1`, `dmem_addr=write_addr`, `dmem_wdata=result`. The stored `result` is the value before this edge.
  - STOP: `halted <= 1`.
  - NOP, and codes 11–15: no datapath change. Codes 11–15 additionally set `illegal`.
- `ovf` is set when any lane of ADD, SUB or MUL, or the DOT sum, is not representable in `DATA_LEN` signed bits.
- While `halted`=1, every opcode is ignored: no register, flag, counter or `dmem_we` change. Only reset clears `halted`.
- `instr_count` increments on opcodes 1–10, including STOP itself. It does not increment while halted.

## Timing
- Reset (async assert, released synchronously by the system): `reg_a`, `reg_b`, `result`, `dmem_addr`, `dmem_wdata` = 0; `dmem_we`, `halted`, `illegal`, `ovf` = 0; `instr_count` = 0.
- Reset mid-operation clears everything immediately, including a pending store: `dmem_we` drops asynchronously.
- Operation latency: 1 cycle. An op at cycle t is visible in `result` at t+1, so back-to-back dependent ops need no bubbles.
  - Example: ADD at t, then STORE at t+1 stores the sum.
  - Example: BUFFER_RES_1 at t+1 loads the sum into `reg_a`.
- `dmem_we` is a registered single-cycle pulse per STORE. Consecutive STOREs give consecutive pulses.
- No backpressure: memory accepts one write per cycle.
- `halted` rises the cycle after STOP. A STORE immediately before STOP still completes its write.

## Configuration
- `EXEC_SATURATE_EN` defined:
  - ADD, SUB and MUL lanes and the DOT sum clamp to `[-2^(DATA_LEN-1), 2^(DATA_LEN-1)-1]` instead of wrapping.
  - DOT saturates only on the final sum; the intermediate accumulation is `2*DATA_LEN+$clog2(PE_ELEMENTS)` bits wide.
  - `ovf` is still set when clamping occurs.
- Undefined: wrap-around (modulo `2^DATA_LEN`) arithmetic.

## Test plan
- LOAD_A {1,2,3,4}, LOAD_B {10,20,30,40}, ADD, STORE addr 0x05 → one `dmem_we` pulse, addr 0x05, data {11,22,33,44}; `instr_count`=4.
- Same operands, then DOT, STORE addr 0x10 → data {300,0,0,0}. Then SUB, STORE → data {-9,-18,-27,-36}.
- Chaining: MUL, BUFFER_RES_1, BUFFER_RES_2, ADD, STORE → with operands {1,2,3,4}/{10,20,30,40}, data {20,80,180,320}.
- Overflow: lane0 0x7FFFFFFF + 1 → wraps to 0x80000000 with `ovf`=1. Under `EXEC_SATURATE_EN` → 0x7FFFFFFF with `ovf`=1.
- STORE, then STOP, then LOAD_A, then STORE → exactly one write; `halted`=1 from the cycle after STOP; `instr_count`=2. Opcode 0xC before STOP → `illegal`=1.
- Assert `rstn` low in the cycle after a STORE → `dmem_we` drops immediately; all outputs are 0 after reset.

Source files
------------

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - SIMD execute stage: operand/result registers, lane-wise ALU, DOT reduction, store issue
// Optional feature macro: EXEC_SATURATE_EN (clamp arithmetic results instead of wrapping).
module execute_stage #(
  parameter int PE_ELEMENTS = 4,
  parameter int DMEM_DEPTH  = 1024,
  parameter int DATA_LEN    = 32,
  localparam int DMEM_ADDR_WIDTH = $clog2(DMEM_DEPTH / PE_ELEMENTS)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [3:0]                      opcode,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] data_a,
  input  logic [PE_ELEMENTS*DATA_LEN-1:0] data_b,
  input  logic [DMEM_ADDR_WIDTH-1:0]      write_addr,
  output logic                            dmem_we,
  output logic [DMEM_ADDR_WIDTH-1:0]      dmem_addr,
  output logic [PE_ELEMENTS*DATA_LEN-1:0] dmem_wdata,
  output logic                            halted,
  output logic                            illegal,
  output logic                            ovf,
  output logic [15:0]                     instr_count
);

  localparam int VEC_W = PE_ELEMENTS * DATA_LEN;
  // Wide enough for a full-precision product plus the growth of summing all lanes.
  localparam int ACC_W = 2 * DATA_LEN + $clog2(PE_ELEMENTS);

  typedef enum logic [3:0] {
    OP_NOP          = 4'd0,
    OP_LOAD_A       = 4'd1,
    OP_LOAD_B       = 4'd2,
    OP_ADD          = 4'd3,
    OP_SUB          = 4'd4,
    OP_MUL          = 4'd5,
    OP_DOT          = 4'd6,
    OP_BUFFER_RES_1 = 4'd7,
    OP_BUFFER_RES_2 = 4'd8,
    OP_STORE        = 4'd9,
    OP_STOP         = 4'd10
  } opcode_e;

  logic [VEC_W-1:0] reg_a;
  logic [VEC_W-1:0] reg_b;
  logic [VEC_W-1:0] result;

  logic [VEC_W-1:0]    add_vec;
  logic [VEC_W-1:0]    sub_vec;
  logic [VEC_W-1:0]    mul_vec;
  logic [DATA_LEN-1:0] dot_val;
  logic                add_ovf;
  logic                sub_ovf;
  logic                mul_ovf;
  logic                dot_ovf;

  // True when a full-precision value is representable in DATA_LEN signed bits:
  // every bit from the DATA_LEN sign position upward must agree.
  function automatic logic fits(input logic signed [ACC_W-1:0] v);
    logic [ACC_W-DATA_LEN:0] top;
    top = v[ACC_W-1:DATA_LEN-1];
    return (top == '0) || (top == '1);
  endfunction

  // Reduce a full-precision value to a lane word: clamp or wrap depending on build.
  function automatic logic [DATA_LEN-1:0] to_word(input logic signed [ACC_W-1:0] v);
`ifdef EXEC_SATURATE_EN
    if (!fits(v)) begin
      if (v[ACC_W-1]) return {1'b1, {(DATA_LEN-1){1'b0}}};
      else            return {1'b0, {(DATA_LEN-1){1'b1}}};
    end
    return v[DATA_LEN-1:0];
`else
    return v[DATA_LEN-1:0];
`endif
  endfunction

  // Compute every arithmetic candidate in full precision from the operand registers.
  always_comb begin
    logic signed [DATA_LEN-1:0] al;
    logic signed [DATA_LEN-1:0] bl;
    logic signed [ACC_W-1:0]    ax;
    logic signed [ACC_W-1:0]    bx;
    logic signed [ACC_W-1:0]    sum_w;
    logic signed [ACC_W-1:0]    dif_w;
    logic signed [ACC_W-1:0]    prd_w;
    logic signed [ACC_W-1:0]    dot_w;
    add_vec = '0;
    sub_vec = '0;
    mul_vec = '0;
    add_ovf = 1'b0;
    sub_ovf = 1'b0;
    mul_ovf = 1'b0;
    dot_w   = '0;
    for (int i = 0; i < PE_ELEMENTS; i++) begin
      al    = reg_a[i*DATA_LEN +: DATA_LEN];
      bl    = reg_b[i*DATA_LEN +: DATA_LEN];
      ax    = al;
      bx    = bl;
      sum_w = ax + bx;
      dif_w = ax - bx;
      prd_w = ax * bx;
      dot_w = dot_w + prd_w;
      add_vec[i*DATA_LEN +: DATA_LEN] = to_word(sum_w);
      sub_vec[i*DATA_LEN +: DATA_LEN] = to_word(dif_w);
      mul_vec[i*DATA_LEN +: DATA_LEN] = to_word(prd_w);
      if (!fits(sum_w)) add_ovf = 1'b1;
      if (!fits(dif_w)) sub_ovf = 1'b1;
      if (!fits(prd_w)) mul_ovf = 1'b1;
    end
    dot_val = to_word(dot_w);
    dot_ovf = !fits(dot_w);
  end

  // Execute one opcode per cycle; once halted, everything freezes until reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      reg_a       <= '0;
      reg_b       <= '0;
      result      <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_wdata  <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
      ovf         <= 1'b0;
      instr_count <= '0;
    end else if (!halted) begin
      dmem_we <= 1'b0;
      if ((opcode inside {[4'd1:4'd10]}) && (instr_count != 16'hFFFF)) begin
        instr_count <= instr_count + 16'd1;
      end
      case (opcode)
        OP_NOP:          ;
        OP_LOAD_A:       reg_a <= data_a;
        OP_LOAD_B:       reg_b <= data_b;
        OP_ADD: begin
          result <= add_vec;
          if (add_ovf) ovf <= 1'b1;
        end
        OP_SUB: begin
          result <= sub_vec;
          if (sub_ovf) ovf <= 1'b1;
        end
        OP_MUL: begin
          result <= mul_vec;
          if (mul_ovf) ovf <= 1'b1;
        end
        OP_DOT: begin
          result <= {{(VEC_W-DATA_LEN){1'b0}}, dot_val};
          if (dot_ovf) ovf <= 1'b1;
        end
        OP_BUFFER_RES_1: reg_a <= result;
        OP_BUFFER_RES_2: reg_b <= result;
        OP_STORE: begin
          dmem_we    <= 1'b1;
          dmem_addr  <= write_addr;
          dmem_wdata <= result;
        end
        OP_STOP:         halted <= 1'b1;
        default:         illegal <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - directed self-checking bench for execute_stage
module tb_execute_stage;

  logic         clk;
  logic         rstn;
  logic [3:0]   opcode;
  logic [127:0] data_a;
  logic [127:0] data_b;
  logic [7:0]   write_addr;
  logic         dmem_we;
  logic [7:0]   dmem_addr;
  logic [127:0] dmem_wdata;
  logic         halted;
  logic         illegal;
  logic         ovf;
  logic [15:0]  instr_count;

  int n_cmp;
  int n_err;

  execute_stage dut (
    .clk         (clk),
    .rstn        (rstn),
    .opcode      (opcode),
    .data_a      (data_a),
    .data_b      (data_b),
    .write_addr  (write_addr),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .halted      (halted),
    .illegal     (illegal),
    .ovf         (ovf),
    .instr_count (instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] vec(input logic [31:0] l0, input logic [31:0] l1,
                                       input logic [31:0] l2, input logic [31:0] l3);
    return {l3, l2, l1, l0};
  endfunction

  // Present one opcode for exactly one rising edge, then return to NOP.
  task automatic issue(input logic [3:0] op, input logic [127:0] a, input logic [127:0] b,
                       input logic [7:0] addr);
    @(negedge clk);
    opcode     = op;
    data_a     = a;
    data_b     = b;
    write_addr = addr;
    @(posedge clk);
    #1;
    opcode = 4'd0;
  endtask

  task automatic op(input logic [3:0] o);
    issue(o, '0, '0, '0);
  endtask

  task automatic check_zero_state(input string tag);
    check({tag, "_we"},      dmem_we,     1'b0);
    check({tag, "_addr"},    dmem_addr,   8'h00);
    check({tag, "_wdata"},   dmem_wdata,  '0);
    check({tag, "_halted"},  halted,      1'b0);
    check({tag, "_illegal"}, illegal,     1'b0);
    check({tag, "_ovf"},     ovf,         1'b0);
    check({tag, "_count"},   instr_count, 16'd0);
  endtask

  logic [127:0] va;
  logic [127:0] vb;
  logic [31:0]  sat_exp;

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rstn       = 1'b0;
    opcode     = 4'd0;
    data_a     = '0;
    data_b     = '0;
    write_addr = '0;
    va = vec(32'd1, 32'd2, 32'd3, 32'd4);
    vb = vec(32'd10, 32'd20, 32'd30, 32'd40);

    repeat (3) @(posedge clk);
    #1;
    check_zero_state("reset");
    @(negedge clk);
    rstn = 1'b1;

    // Basic ADD and store
    issue(4'd1, va, '0, '0);
    issue(4'd2, '0, vb, '0);
    op(4'd3);
    issue(4'd9, '0, '0, 8'h05);
    check("add_we",    dmem_we,     1'b1);
    check("add_addr",  dmem_addr,   8'h05);
    check("add_data",  dmem_wdata,  vec(32'd11, 32'd22, 32'd33, 32'd44));
    check("add_count", instr_count, 16'd4);
    op(4'd0);
    check("pulse_end", dmem_we,     1'b0);
    check("nop_count", instr_count, 16'd4);

    // DOT and SUB
    op(4'd6);
    issue(4'd9, '0, '0, 8'h10);
    check("dot_addr", dmem_addr,  8'h10);
    check("dot_data", dmem_wdata, vec(32'd300, 32'd0, 32'd0, 32'd0));
    op(4'd4);
    issue(4'd9, '0, '0, 8'h11);
    check("sub_data", dmem_wdata, vec(32'hFFFF_FFF7, 32'hFFFF_FFEE, 32'hFFFF_FFE5, 32'hFFFF_FFDC));

    // Chaining through result buffers
    op(4'd5);
    op(4'd7);
    op(4'd8);
    op(4'd3);
    issue(4'd9, '0, '0, 8'h20);
    check("chain_data",  dmem_wdata,  vec(32'd20, 32'd80, 32'd180, 32'd320));
    check("chain_ovf",   ovf,         1'b0);
    check("chain_count", instr_count, 16'd13);

    // Overflow, then back-to-back stores
`ifdef EXEC_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8000_0000;
`endif
    issue(4'd1, vec(32'h7FFF_FFFF, 32'd0, 32'd0, 32'd0), '0, '0);
    issue(4'd2, '0, vec(32'd1, 32'd0, 32'd0, 32'd0), '0);
    op(4'd3);
    check("ovf_flag", ovf, 1'b1);
    issue(4'd9, '0, '0, 8'h30);
    check("ovf_we",   dmem_we,    1'b1);
    check("ovf_data", dmem_wdata, vec(sat_exp, 32'd0, 32'd0, 32'd0));
    issue(4'd9, '0, '0, 8'h31);
    check("b2b_we",    dmem_we,     1'b1);
    check("b2b_addr",  dmem_addr,   8'h31);
    check("b2b_count", instr_count, 16'd18);

    // Asynchronous reset while a store pulse is high
    issue(4'd9, '0, '0, 8'h32);
    check("pre_rst_we", dmem_we, 1'b1);
    #2;
    rstn = 1'b0;
    #1;
    check_zero_state("async_rst");
    @(negedge clk);
    rstn = 1'b1;

    // Illegal opcode, then halt behaviour
    op(4'hC);
    check("illegal_flag",  illegal,     1'b1);
    check("illegal_count", instr_count, 16'd0);
    issue(4'd9, '0, '0, 8'h07);
    check("pre_stop_we",     dmem_we,   1'b1);
    check("pre_stop_addr",   dmem_addr, 8'h07);
    check("pre_stop_halted", halted,    1'b0);
    op(4'd10);
    check("stop_halted", halted,      1'b1);
    check("stop_we",     dmem_we,     1'b0);
    check("stop_count",  instr_count, 16'd2);
    issue(4'd1, va, '0, '0);
    check("halt_load_count", instr_count, 16'd2);
    issue(4'd9, '0, '0, 8'h08);
    check("halt_store_we",   dmem_we,     1'b0);
    check("halt_store_addr", dmem_addr,   8'h07);
    check("halt_count",      instr_count, 16'd2);
    check("halt_sticky",     halted,      1'b1);
    check("halt_illegal",    illegal,     1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
